debug_unit: RTL and testbench

- Host-side controller for the pipeline's debug interface; drives the pipeline's write, enable, instruction and debug-address inputs.
- Consumes the pipeline's PC, memory, register and halt outputs.
- Takes command bytes from a UART receiver and loads programs word by word.
- Runs programs in continuous or single-step mode, then streams a full state dump (PC, registers, data memory) to a UART transmitter.

---
 rtl/debug_unit_if.sv | 33 +++
 rtl/debug_unit.sv | 214 +++++++++++++++++++++
 tb/tb_debug_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_unit_if.sv
// Debug-unit bus: UART byte streams plus pipeline debug controls and observations.
// slave = debug_unit side, master = UART/pipeline side.
interface debug_unit_if #(
    parameter int INST_SZ = 32,
    parameter int PC_SZ   = 32,
    parameter int REG_SZ  = 5,
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_write;
    logic [INST_SZ-1:0] o_instruction;
    logic               o_enable;
    logic [REG_SZ-1:0]  o_debug_addr;
    logic [PC_SZ-1:0]   i_pc;
    logic [INST_SZ-1:0] i_reg;
    logic [INST_SZ-1:0] i_mem;
    logic               i_halt;
    logic               o_busy;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_pc, i_reg, i_mem, i_halt,
        output o_tx_data, o_tx_start, o_write, o_instruction, o_enable, o_debug_addr, o_busy
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_pc, i_reg, i_mem, i_halt,
        input  o_tx_data, o_tx_start, o_write, o_instruction, o_enable, o_debug_addr, o_busy
    );
endinterface

// File: rtl/debug_unit.sv
// Host-side pipeline debug controller: UART commands L/C/S/D load, run, step and dump state.
// Define DEBUG_UNIT_CHECKSUM_EN to append an XOR checksum byte after each dump.
module debug_unit #(
    parameter int INST_SZ     = 32,
    parameter int PC_SZ       = 32,
    parameter int REG_SZ      = 5,
    parameter int NB_DATA     = 8,
    parameter int RUN_TIMEOUT = 1000000
) (
    input logic         i_clk,
    input logic         i_reset,
    debug_unit_if.slave bus
);
    localparam int BYTES = INST_SZ / NB_DATA;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TW    = $clog2(RUN_TIMEOUT + 1);
    localparam int SW    = INST_SZ - NB_DATA;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] LOAD_CNT   = 4'd1;
    localparam logic [3:0] LOAD_BYTE  = 4'd2;
    localparam logic [3:0] LOAD_WRITE = 4'd3;
    localparam logic [3:0] RUN        = 4'd4;
    localparam logic [3:0] STEP       = 4'd5;
    localparam logic [3:0] DUMP_ADDR  = 4'd6;
    localparam logic [3:0] DUMP_SEND  = 4'd7;
    localparam logic [3:0] DUMP_WAIT  = 4'd8;
`ifdef DEBUG_UNIT_CHECKSUM_EN
    localparam logic [3:0] SUM_SEND   = 4'd9;
    localparam logic [3:0] SUM_WAIT   = 4'd10;
`endif

    localparam logic [1:0] PH_PC  = 2'd0;
    localparam logic [1:0] PH_REG = 2'd1;
    localparam logic [1:0] PH_MEM = 2'd2;

    logic [3:0]         state_q,    state_d;
    logic [NB_DATA-1:0] cnt_q,      cnt_d;
    logic [BW-1:0]      byte_q,     byte_d;
    logic [SW-1:0]      shift_q,    shift_d;
    logic [INST_SZ-1:0] instr_q,    instr_d;
    logic [INST_SZ-1:0] word_q,     word_d;
    logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [REG_SZ-1:0]  addr_q,     addr_d;
    logic [1:0]         phase_q,    phase_d;
    logic [TW-1:0]      timer_q,    timer_d;
`ifdef DEBUG_UNIT_CHECKSUM_EN
    logic [NB_DATA-1:0] csum_q,     csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        instr_d    = instr_q;
        word_d     = word_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        addr_d     = addr_q;
        phase_d    = phase_q;
        timer_d    = timer_q;
`ifdef DEBUG_UNIT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_rx_done) begin
                    phase_d = PH_PC;
                    timer_d = '0;
`ifdef DEBUG_UNIT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    if (bus.i_rx_data == NB_DATA'('h4C))      state_d = LOAD_CNT;
                    else if (bus.i_rx_data == NB_DATA'('h43)) state_d = RUN;
                    else if (bus.i_rx_data == NB_DATA'('h53)) state_d = STEP;
                    else if (bus.i_rx_data == NB_DATA'('h44)) state_d = DUMP_ADDR;
                end
            end
            LOAD_CNT: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = bus.i_rx_data;
                        byte_d  = '0;
                        state_d = LOAD_BYTE;
                    end
                end
            end
            LOAD_BYTE: begin
                if (bus.i_rx_done) begin
                    if (byte_q == LAST_BYTE) begin
                        instr_d = {shift_q, bus.i_rx_data};
                        byte_d  = '0;
                        state_d = LOAD_WRITE;
                    end else begin
                        shift_d = {shift_q[SW-NB_DATA-1:0], bus.i_rx_data};
                        byte_d  = byte_q + 1'b1;
                    end
                end
            end
            LOAD_WRITE: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == NB_DATA'(1)) ? IDLE : LOAD_BYTE;
            end
            RUN: begin
                if (bus.i_halt || timer_q == TW'(RUN_TIMEOUT - 1)) begin
                    timer_d = '0;
                    state_d = DUMP_ADDR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STEP: state_d = DUMP_ADDR;
            // o_debug_addr has been stable for this whole cycle; latch the word at its end.
            DUMP_ADDR: begin
                if (phase_q == PH_PC)       word_d = INST_SZ'(bus.i_pc);
                else if (phase_q == PH_REG) word_d = bus.i_reg;
                else                        word_d = bus.i_mem;
                byte_d  = '0;
                state_d = DUMP_SEND;
            end
            DUMP_SEND: begin
                tx_data_d  = word_q[INST_SZ-1 -: NB_DATA];
                tx_start_d = 1'b1;
                word_d     = word_q << NB_DATA;
`ifdef DEBUG_UNIT_CHECKSUM_EN
                csum_d     = csum_q ^ word_q[INST_SZ-1 -: NB_DATA];
`endif
                state_d    = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (bus.i_tx_done) begin
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = DUMP_SEND;
                    end else if (phase_q == PH_PC) begin
                        phase_d = PH_REG;
                        state_d = DUMP_ADDR;
                    end else begin
                        // The address wraps to 0 both into the memory phase and at dump end.
                        addr_d  = addr_q + 1'b1;
                        state_d = DUMP_ADDR;
                        if (addr_q == '1) begin
                            if (phase_q == PH_REG) begin
                                phase_d = PH_MEM;
                            end else begin
`ifdef DEBUG_UNIT_CHECKSUM_EN
                                state_d = SUM_SEND;
`else
                                state_d = IDLE;
`endif
                            end
                        end
                    end
                end
            end
`ifdef DEBUG_UNIT_CHECKSUM_EN
            SUM_SEND: begin
                tx_data_d  = csum_q;
                tx_start_d = 1'b1;
                state_d    = SUM_WAIT;
            end
            SUM_WAIT: if (bus.i_tx_done) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            instr_q    <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            addr_q     <= '0;
            phase_q    <= PH_PC;
            timer_q    <= '0;
`ifdef DEBUG_UNIT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            instr_q    <= instr_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            timer_q    <= timer_d;
`ifdef DEBUG_UNIT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_tx_start    = tx_start_q;
    assign bus.o_write       = (state_q == LOAD_WRITE);
    assign bus.o_instruction = instr_q;
    assign bus.o_enable      = ((state_q == RUN) || (state_q == STEP)) && !bus.i_halt;
    assign bus.o_debug_addr  = addr_q;
    assign bus.o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: stimulus pushes expected TX bytes / writes, a monitor pops and compares.
module tb_debug_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_unit_if #(.INST_SZ(32), .PC_SZ(32), .REG_SZ(5), .NB_DATA(8)) dbg ();

    debug_unit #(
        .INST_SZ(32), .PC_SZ(32), .REG_SZ(5), .NB_DATA(8), .RUN_TIMEOUT(16)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (dbg)
    );

    logic [31:0] regs [32];
    logic [31:0] mem  [32];
    assign dbg.i_reg = regs[dbg.o_debug_addr];
    assign dbg.i_mem = mem[dbg.o_debug_addr];

    logic [7:0]  exp_tx [$];
    logic [31:0] exp_wr [$];
    int checks = 0;
    int passed = 0;
    int tx_cnt = 0;
    int wr_cnt = 0;
    int act_cnt = 0;
    int en_cnt = 0;
    int halt_after = 0;
    logic [7:0] cs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (dbg.o_tx_start || dbg.o_write || dbg.o_enable || dbg.o_busy) act_cnt++;
        if (dbg.o_tx_start) begin
            tx_cnt++;
            if (exp_tx.size() == 0) begin
                checks++;
                $display("FAIL tx_extra: got byte %h, expected no byte", dbg.o_tx_data);
            end else begin
                check("tx_byte", {24'h0, dbg.o_tx_data}, {24'h0, exp_tx.pop_front()});
            end
        end
        if (dbg.o_write) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
                checks++;
                $display("FAIL wr_extra: got word %h, expected no write", dbg.o_instruction);
            end else begin
                check("write_word", dbg.o_instruction, exp_wr.pop_front());
            end
        end
    end

    // Pipeline halt model: raises i_halt after halt_after enabled cycles.
    initial forever begin
        @(negedge clk);
        if (dbg.o_enable) en_cnt++;
        if (halt_after != 0 && en_cnt == halt_after) dbg.i_halt = 1'b1;
    end

    // UART TX model: i_tx_done one-cycle pulse two edges after each start.
    initial forever begin
        @(negedge clk);
        if (dbg.o_tx_start) begin
            @(posedge clk); #1 dbg.i_tx_done = 1'b1;
            @(posedge clk); #1 dbg.i_tx_done = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1 dbg.i_rx_data = b; dbg.i_rx_done = 1'b1;
        @(posedge clk); #1 dbg.i_rx_done = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) begin
            logic [7:0] by;
            by = w[b*8 +: 8];
            exp_tx.push_back(by);
            cs ^= by;
        end
    endtask

    task automatic push_dump();
        cs = 8'h00;
        push_word(dbg.i_pc);
        for (int i = 0; i < 32; i++) push_word(regs[i]);
        for (int i = 0; i < 32; i++) push_word(mem[i]);
`ifdef DEBUG_UNIT_CHECKSUM_EN
        exp_tx.push_back(cs);
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (dbg.o_busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, dbg.o_busy}, 32'h0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  {31'h0, dbg.o_busy},     32'h0);
        check({tag, "_en"},    {31'h0, dbg.o_enable},   32'h0);
        check({tag, "_wr"},    {31'h0, dbg.o_write},    32'h0);
        check({tag, "_start"}, {31'h0, dbg.o_tx_start}, 32'h0);
        check({tag, "_txd"},   {24'h0, dbg.o_tx_data},  32'h0);
        check({tag, "_addr"},  {27'h0, dbg.o_debug_addr}, 32'h0);
        check({tag, "_instr"}, dbg.o_instruction,       32'h0);
    endtask

    initial begin
        int base;
        int n;
        dbg.i_rx_data = 8'h00;
        dbg.i_rx_done = 1'b0;
        dbg.i_tx_done = 1'b0;
        dbg.i_halt    = 1'b0;
        dbg.i_pc      = 32'h0040_0010;
        for (int i = 0; i < 32; i++) begin
            regs[i] = (i == 1) ? 32'h0000_0005 : (32'hA500_0000 | (i << 8) | i);
            mem[i]  = 32'hC0DE_0000 + i * 3;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Load two words
        exp_wr.push_back(32'h2001_0005);
        exp_wr.push_back(32'hFFFF_FFFF);
        send_rx(8'h4C); send_rx(8'h02);
        send_rx(8'h20); send_rx(8'h01); send_rx(8'h00); send_rx(8'h05);
        send_rx(8'hFF); send_rx(8'hFF); send_rx(8'hFF); send_rx(8'hFF);
        wait_idle("load_idle");
        check("load_writes", wr_cnt, 2);
        check("load_instr_hold", dbg.o_instruction, 32'hFFFF_FFFF);

        // Zero-length load
        send_rx(8'h4C); send_rx(8'h00);
        wait_idle("load0_idle");
        check("load0_writes", wr_cnt, 2);

        // Continuous run, halt after 10 cycles
        en_cnt = 0; halt_after = 10;
        push_dump();
        send_rx(8'h43);
        wait_idle("run_idle");
        check("run_enable_cycles", en_cnt, 10);
        check("run_dump_drained", exp_tx.size(), 0);

        // Single step
        halt_after = 0; dbg.i_halt = 1'b0; en_cnt = 0;
        push_dump();
        send_rx(8'h53);
        wait_idle("step_idle");
        check("step_enable_cycles", en_cnt, 1);
        check("step_dump_drained", exp_tx.size(), 0);

        // Step while halted
        dbg.i_halt = 1'b1; en_cnt = 0;
        push_dump();
        send_rx(8'h53);
        wait_idle("step_halt_idle");
        check("step_halt_enable_cycles", en_cnt, 0);

        // Run timeout
        dbg.i_halt = 1'b0; en_cnt = 0;
        push_dump();
        send_rx(8'h43);
        wait_idle("timeout_idle");
        check("timeout_enable_cycles", en_cnt, 16);
        check("timeout_dump_drained", exp_tx.size(), 0);

        // Reset after 100 dump bytes
        push_dump();
        base = tx_cnt;
        send_rx(8'h44);
        n = 0;
        while (tx_cnt - base < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("middump_reached_100", tx_cnt - base, 100);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("middump_reset");
        exp_tx.delete();
        repeat (5) @(posedge clk);

        // Zeroed state dump, PC = 4 (checksum byte = 0x04 when enabled)
        dbg.i_pc = 32'h0000_0004;
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'h0;
            mem[i]  = 32'h0;
        end
        en_cnt = 0;
        base = tx_cnt;
        push_dump();
        send_rx(8'h44);
        wait_idle("dump_idle");
`ifdef DEBUG_UNIT_CHECKSUM_EN
        check("dump_len", tx_cnt - base, 261);
`else
        check("dump_len", tx_cnt - base, 260);
`endif
        check("dump_no_enable", en_cnt, 0);
        check("dump_drained", exp_tx.size(), 0);

        // Junk byte in IDLE
        base = act_cnt;
        send_rx(8'h7A);
        repeat (20) @(negedge clk);
        check("junk_no_activity", act_cnt - base, 0);
        check("junk_writes", wr_cnt, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
